// File: rtl/serial_adder.sv
// Bit-serial ripple adder: {cout,sum} = a + b + cin, one bit per clock, LSB first.
// One full-adder cell with a registered carry is reused over WIDTH RUN cycles.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         request, sampled only while idle
//   a, b, cin     operands, latched when start is accepted
//   sum, cout     registered result, held until the next accepted start
//   ovf           signed overflow (only with SERIAL_ADDER_OVF_EN defined)
//   busy          high while running and during the done cycle
//   done          one-cycle pulse when sum/cout are final
//
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the ovf output.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             bit_s;
    logic             carry_n;
    logic             last_s;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Single full-adder cell on the current LSBs.
    assign bit_s   = sa_q[0] ^ sb_q[0] ^ carry_q;
    assign carry_n = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q)
                   | (sb_q[0] & carry_q);
    assign last_s  = (cnt_q == LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_s) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            S_IDLE:  ;
            S_RUN:   busy = 1'b1;
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath next-state
    always_comb begin
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    carry_d = cin;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                res_d   = {bit_s, res_q[WIDTH-1:1]};
                carry_d = carry_n;
                cnt_d   = cnt_q + CW'(1);
                if (last_s) begin
                    // res_d already holds the completed word here.
                    sum_d  = {bit_s, res_q[WIDTH-1:1]};
                    cout_d = carry_n;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB cell.
                    ovf_d  = carry_q ^ carry_n;
`endif
                end
            end
            S_DONE:  ;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: directed corner cases plus random operands
// checked against an arithmetic reference model.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       busy, done;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf;
`endif

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] last_sum;
    logic       last_cout;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf   (ovf),
`endif
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One operation; poke>=0 raises a stray start after that many RUN edges.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                          input logic ci, input int poke);
        logic [8:0] e;
        int n;
        e = {1'b0, x} + {1'b0, y} + {8'd0, ci};
        @(negedge clk);
        a = x; b = y; cin = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        check("busy_run", busy, 1);
        check("hold_sum", sum, last_sum);
        check("hold_cout", cout, last_cout);
        n = 0;
        while (!done && n < 20) begin
            if (n == poke) begin
                start = 1'b1; a = 8'hAA; b = 8'h55;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        check("latency", n, 8);
        check("sum", sum, e[7:0]);
        check("cout", cout, e[8]);
        check("busy_done", busy, 1);
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", ovf, (x[7] == y[7]) && (e[7] != x[7]));
`endif
        last_sum = e[7:0];
        last_cout = e[8];
        @(posedge clk); #1;
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        int edges;
        int seen;
        int prev;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        last_sum = '0; last_cout = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        rst = 1'b0;

        run_op(8'h3C, 8'h29, 1'b0, -1);
        run_op(8'hFF, 8'h01, 1'b0, -1);
        run_op(8'hFF, 8'hFF, 1'b1, -1);
        run_op(8'h7F, 8'h00, 1'b1, -1);
        run_op(8'h80, 8'h80, 1'b0, -1);

        // Stray start mid-run is dropped, and no second operation follows.
        run_op(8'h10, 8'h20, 1'b0, 2);
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("no_extra_done", seen, 0);

        // Reset in the middle of RUN discards the partial result.
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_sum", sum, 0);
        check("mrst_cout", cout, 0);
        last_sum = '0; last_cout = 1'b0;
        run_op(8'h12, 8'h34, 1'b0, -1);

        // start held high: back-to-back operations every WIDTH+2 cycles.
        @(negedge clk);
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        edges = 0; seen = 0; prev = 0;
        while (seen < 3 && edges < 60) begin
            @(posedge clk); #1;
            edges++;
            if (done) begin
                check("held_sum", sum, 8'h02);
                check("held_cout", cout, 0);
                if (seen > 0) check("held_period", edges - prev, 10);
                prev = edges;
                seen++;
            end
            if (busy && !done) begin
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            end else begin
                a = 8'h01; b = 8'h01; cin = 1'b0;
            end
        end
        check("held_count", seen, 3);
        start = 1'b0;
        edges = 0;
        while (busy && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        check("held_drain", busy, 0);
        last_sum = 8'h02; last_cout = 1'b0;

        for (int i = 0; i < 20; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
